// File: rtl/move_input_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// move_input_conditioner_pkg
//
// Shared definitions for the move input conditioner and the room state
// machine that consumes its direction pulses.
//
//   move_state_t : conditioner FSM states (IDLE, PULSE, HOLDOFF)
//   move_dir_t   : one-hot direction vector, bit order {n, s, w, e}
//   DIR_*        : named one-hot direction constants
//   pick_dir     : fixed-priority (n > s > w > e) reduction of a press vector
//                  to a single one-hot direction
// -----------------------------------------------------------------------------
package move_input_conditioner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PULSE   = 2'd1,
        ST_HOLDOFF = 2'd2
    } move_state_t;

    // One-hot direction, bit 3 = north ... bit 0 = east.
    typedef logic [3:0] move_dir_t;

    localparam move_dir_t DIR_NONE = 4'b0000;
    localparam move_dir_t DIR_N    = 4'b1000;
    localparam move_dir_t DIR_S    = 4'b0100;
    localparam move_dir_t DIR_W    = 4'b0010;
    localparam move_dir_t DIR_E    = 4'b0001;

    // Keep only the highest-priority pressed direction; the rest are dropped.
    function automatic move_dir_t pick_dir(input logic [3:0] press);
        move_dir_t dir;
        dir = DIR_NONE;
        if (press[3])      dir = DIR_N;
        else if (press[2]) dir = DIR_S;
        else if (press[1]) dir = DIR_W;
        else if (press[0]) dir = DIR_E;
        return dir;
    endfunction

endpackage

// File: rtl/move_input_conditioner_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//
// Conditions one raw push-button level: two-flop synchronizer, a hold counter
// that accepts a new level only after it has been stable for DEBOUNCE_CYCLES
// synchronized cycles, and a rising-edge detector on the accepted level.
//
// Parameters:
//   DEBOUNCE_CYCLES : cycles a level must hold before acceptance (2..255)
//
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-low reset
//   raw   : asynchronous raw button level, 1 = pressed
//   rise  : one-cycle press event (accepted level went 0 -> 1)
// -----------------------------------------------------------------------------
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic rise
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic       sync1;
    logic       sync2;
    logic       deb;
    logic       deb_d;
    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            deb   <= 1'b0;
            deb_d <= 1'b0;
            cnt   <= 8'd0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_d <= deb;
            // Any cycle that agrees with the accepted level restarts the
            // qualification, so a bouncing input never accumulates.
            if (sync2 == deb) begin
                cnt <= 8'd0;
            end else if (cnt == CNT_LAST) begin
                deb <= sync2;
                cnt <= 8'd0;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    // Release (deb falling) intentionally produces no event.
    assign rise = deb & ~deb_d;

endmodule

// File: rtl/move_input_conditioner.sv
// -----------------------------------------------------------------------------
// move_input_conditioner
//
// Turns four raw direction buttons into clean single-cycle move pulses for
// the room state machine. Each button is debounced; a press event in IDLE
// (and not frozen) produces exactly one one-hot pulse, chosen by priority
// n > s > w > e, followed by a holdoff window during which further presses
// are discarded rather than queued.
//
// Parameters:
//   DEBOUNCE_CYCLES : debounce qualification length (2..255)
//   HOLDOFF_CYCLES  : cycles of press suppression after a pulse (1..255)
//
// Ports:
//   clk                        : clock, rising edge
//   reset                      : synchronous, active-low reset
//   btn_n, btn_s, btn_w, btn_e : raw button levels, 1 = pressed
//   freeze                     : 1 = suppress moves (game over)
//   n, s, w, e                 : registered one-cycle move pulses
//   move_count                 : registered count of emitted moves, saturating
//   busy                       : registered, 1 in PULSE or HOLDOFF
//   state                      : current FSM state, for observation
//
// Handshake: there is no back-pressure. A pulse on n/s/w/e is valid for
// exactly one cycle and the consumer must take it in that cycle; at most one
// of the four is high in any cycle.
// -----------------------------------------------------------------------------
module move_input_conditioner
    import move_input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLDOFF_CYCLES  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_n,
    input  logic        btn_s,
    input  logic        btn_w,
    input  logic        btn_e,
    input  logic        freeze,
    output logic        n,
    output logic        s,
    output logic        w,
    output logic        e,
    output logic [7:0]  move_count,
    output logic        busy,
    output move_state_t state
);

    localparam logic [7:0] HOLD_LOAD = 8'(HOLDOFF_CYCLES - 1);

    logic [3:0]  press;
    move_state_t cur_state;
    move_state_t next_state;
    move_dir_t   dir_q;
    move_dir_t   next_dir;
    logic [7:0]  hold_cnt;
    logic [7:0]  hold_next;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_n (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_n),
        .rise  (press[3])
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_s (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_s),
        .rise  (press[2])
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_w (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_w),
        .rise  (press[1])
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_e (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_e),
        .rise  (press[0])
    );

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cur_state  <= ST_IDLE;
            hold_cnt   <= 8'd0;
            dir_q      <= DIR_NONE;
            busy       <= 1'b0;
            move_count <= 8'd0;
        end else begin
            cur_state <= next_state;
            hold_cnt  <= hold_next;
            dir_q     <= next_dir;
            busy      <= (next_state != ST_IDLE);
            // Counted on the same edge that makes the pulse visible.
            if ((next_dir != DIR_NONE) && (move_count != 8'hFF)) begin
                move_count <= move_count + 8'd1;
            end
        end
    end

    // Next-state logic. Press events only matter in IDLE; anywhere else they
    // fall through untouched, which is what discards them. Freeze only gates
    // the IDLE -> PULSE decision, so a pulse already launched still finishes.
    always_comb begin
        next_state = cur_state;
        next_dir   = DIR_NONE;
        hold_next  = hold_cnt;
        case (cur_state)
            ST_IDLE: begin
                if (!freeze && (press != 4'b0000)) begin
                    next_state = ST_PULSE;
                    next_dir   = pick_dir(press);
                end
            end
            ST_PULSE: begin
                next_state = ST_HOLDOFF;
                hold_next  = HOLD_LOAD;
            end
            ST_HOLDOFF: begin
                if (hold_cnt == 8'd0) begin
                    next_state = ST_IDLE;
                end else begin
                    hold_next = hold_cnt - 8'd1;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    assign {n, s, w, e} = dir_q;
    assign state        = cur_state;

endmodule

// File: tb/tb_move_input_conditioner.sv
module tb_move_input_conditioner;
    import move_input_conditioner_pkg::*;

    localparam int DEB  = 4;
    localparam int HOLD = 2;
    localparam int LAT  = DEB + 2;   // edge index at which the pulse appears

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        btn_n = 1'b0;
    logic        btn_s = 1'b0;
    logic        btn_w = 1'b0;
    logic        btn_e = 1'b0;
    logic        freeze = 1'b0;
    logic        n, s, w, e;
    logic [7:0]  move_count;
    logic        busy;
    move_state_t state;

    int checks = 0;
    int fails = 0;
    int exp_count = 0;

    move_input_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .HOLDOFF_CYCLES  (HOLD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_n      (btn_n),
        .btn_s      (btn_s),
        .btn_w      (btn_w),
        .btn_e      (btn_e),
        .freeze     (freeze),
        .n          (n),
        .s          (s),
        .w          (w),
        .e          (e),
        .move_count (move_count),
        .busy       (busy),
        .state      (state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    // Advance past one rising edge; outputs then reflect that edge, and any
    // input written now is first sampled at the following edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic release_all();
        btn_n  = 1'b0;
        btn_s  = 1'b0;
        btn_w  = 1'b0;
        btn_e  = 1'b0;
        freeze = 1'b0;
        repeat (14) tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        checks++;
        if ({n, s, w, e} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_dirs: got %b expected 0000", {n, s, w, e});
        end
        checks++;
        if (move_count !== 8'd0) begin
            fails++;
            $display("FAIL reset_count: got %0d expected 0", move_count);
        end
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
        checks++;
        if (state !== ST_IDLE) begin
            fails++;
            $display("FAIL reset_state: got %0d expected IDLE", state);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_latency();
        logic       exp_e;
        logic       exp_busy;
        logic [7:0] exp_mc;
        btn_e = 1'b1;
        for (int i = 0; i <= 12; i++) begin
            tick();
            exp_e    = (i == LAT);
            exp_busy = (i >= LAT) && (i <= LAT + HOLD);
            exp_mc   = (i >= LAT) ? 8'(exp_count + 1) : 8'(exp_count);
            checks++;
            if ({n, s, w, e} !== {3'b000, exp_e}) begin
                fails++;
                $display("FAIL latency_dirs @%0d: got %b expected %b", i, {n, s, w, e}, {3'b000, exp_e});
            end
            checks++;
            if (busy !== exp_busy) begin
                fails++;
                $display("FAIL latency_busy @%0d: got %b expected %b", i, busy, exp_busy);
            end
            checks++;
            if (move_count !== exp_mc) begin
                fails++;
                $display("FAIL latency_count @%0d: got %0d expected %0d", i, move_count, exp_mc);
            end
        end
        exp_count++;
        release_all();
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 36; i++) begin
            btn_n = ((i % 6) < 3);
            tick();
            checks++;
            if ({n, s, w, e} !== 4'b0000) begin
                fails++;
                $display("FAIL bounce_dirs @%0d: got %b expected 0000", i, {n, s, w, e});
            end
        end
        release_all();
        checks++;
        if (move_count !== 8'(exp_count)) begin
            fails++;
            $display("FAIL bounce_count: got %0d expected %0d", move_count, exp_count);
        end
    endtask

    task automatic test_priority();
        // w and s together: only s.
        btn_w = 1'b1;
        btn_s = 1'b1;
        for (int i = 0; i <= 12; i++) begin
            tick();
            checks++;
            if ({n, s, w, e} !== {1'b0, (i == LAT), 2'b00}) begin
                fails++;
                $display("FAIL priority_same @%0d: got %b expected %b", i, {n, s, w, e}, {1'b0, (i == LAT), 2'b00});
            end
        end
        exp_count++;
        release_all();
        // w pressed two cycles after s: its event lands in HOLDOFF.
        btn_s = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 1) btn_w = 1'b1;
            checks++;
            if ({n, s, w, e} !== {1'b0, (i == LAT), 2'b00}) begin
                fails++;
                $display("FAIL priority_holdoff @%0d: got %b expected %b", i, {n, s, w, e}, {1'b0, (i == LAT), 2'b00});
            end
        end
        exp_count++;
        checks++;
        if (move_count !== 8'(exp_count)) begin
            fails++;
            $display("FAIL priority_count: got %0d expected %0d", move_count, exp_count);
        end
        release_all();
    endtask

    task automatic test_freeze();
        freeze = 1'b1;
        btn_e  = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            checks++;
            if ({n, s, w, e} !== 4'b0000) begin
                fails++;
                $display("FAIL freeze_held @%0d: got %b expected 0000", i, {n, s, w, e});
            end
        end
        freeze = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            checks++;
            if ({n, s, w, e} !== 4'b0000) begin
                fails++;
                $display("FAIL freeze_released @%0d: got %b expected 0000", i, {n, s, w, e});
            end
        end
        checks++;
        if (move_count !== 8'(exp_count)) begin
            fails++;
            $display("FAIL freeze_count: got %0d expected %0d", move_count, exp_count);
        end
        btn_e = 1'b0;
        repeat (10) tick();
        // Re-press; freeze rises right after the pulse appears and must not cut
        // the holdoff short.
        btn_e = 1'b1;
        for (int i = 0; i <= 12; i++) begin
            tick();
            if (i == LAT) freeze = 1'b1;
            checks++;
            if ({n, s, w, e} !== {3'b000, (i == LAT)}) begin
                fails++;
                $display("FAIL freeze_repress @%0d: got %b expected %b", i, {n, s, w, e}, {3'b000, (i == LAT)});
            end
            checks++;
            if (busy !== ((i >= LAT) && (i <= LAT + HOLD))) begin
                fails++;
                $display("FAIL freeze_busy @%0d: got %b expected %b", i, busy, ((i >= LAT) && (i <= LAT + HOLD)));
            end
        end
        exp_count++;
        checks++;
        if (move_count !== 8'(exp_count)) begin
            fails++;
            $display("FAIL freeze_repress_count: got %0d expected %0d", move_count, exp_count);
        end
        release_all();
    endtask

    task automatic test_reset_during_pulse();
        btn_n = 1'b1;
        for (int i = 0; i <= LAT; i++) tick();
        checks++;
        if ({n, s, w, e} !== 4'b1000) begin
            fails++;
            $display("FAIL rst_pulse_pre: got %b expected 1000", {n, s, w, e});
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({n, s, w, e, busy} !== 5'b00000) begin
            fails++;
            $display("FAIL rst_pulse_outputs: got %b expected 00000", {n, s, w, e, busy});
        end
        checks++;
        if (move_count !== 8'd0) begin
            fails++;
            $display("FAIL rst_pulse_count: got %0d expected 0", move_count);
        end
        checks++;
        if (state !== ST_IDLE) begin
            fails++;
            $display("FAIL rst_pulse_state: got %0d expected IDLE", state);
        end
        reset = 1'b1;
        for (int i = 0; i <= 14; i++) begin
            tick();
            checks++;
            if ({n, s, w, e} !== {(i == LAT), 3'b000}) begin
                fails++;
                $display("FAIL rst_requalify @%0d: got %b expected %b", i, {n, s, w, e}, {(i == LAT), 3'b000});
            end
        end
        exp_count = 1;
        checks++;
        if (move_count !== 8'(exp_count)) begin
            fails++;
            $display("FAIL rst_requalify_count: got %0d expected %0d", move_count, exp_count);
        end
        release_all();
    endtask

    task automatic test_saturation();
        for (int p = 0; p < 300; p++) begin
            btn_e = 1'b1;
            repeat (10) tick();
            btn_e = 1'b0;
            repeat (10) tick();
            if (exp_count < 255) exp_count++;
            checks++;
            if (move_count !== 8'(exp_count)) begin
                fails++;
                $display("FAIL saturation @%0d: got %0d expected %0d", p, move_count, exp_count);
            end
        end
        checks++;
        if (move_count !== 8'd255) begin
            fails++;
            $display("FAIL saturation_final: got %0d expected 255", move_count);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_latency();
        test_bounce();
        test_priority();
        test_freeze();
        test_reset_during_pulse();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/move_input_conditioner.md
MOVE_INPUT_CONDITIONER -- requirements
Module: move_input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive synchronized cycles a button level must hold before it is accepted; legal range 2..255.
REQ-002 Parameter HOLDOFF_CYCLES, default 4: cycles after an emitted move during which new presses are discarded; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 btn_n, btn_s, btn_w, btn_e  input  1 each  raw asynchronous push-button levels, 1 = pressed.
REQ-006 freeze  input  1  game-over hold; 1 = suppress all moves.
REQ-007 n, s, w, e  output  1 each  registered single-cycle move pulses that drive the room state machine direction inputs.
REQ-008 move_count  output  8  registered count of emitted moves.
REQ-009 busy  output  1  registered; 1 while the FSM is in PULSE or HOLDOFF.

Function
REQ-010 Each button SHALL pass through a two-flop synchronizer before any other logic.
REQ-011 Each button SHALL have a debounced level deb (reset 0) and a counter cnt (reset 0); when the synchronized level equals deb, cnt SHALL clear to 0.
REQ-012 When the synchronized level differs from deb and cnt == DEBOUNCE_CYCLES-1, deb SHALL take the synchronized level and cnt SHALL clear; otherwise cnt SHALL increment.
REQ-013 A press event SHALL be deb rising, with deb delayed by one register stage. Deb falling SHALL generate no event.
REQ-014 The FSM SHALL have states IDLE, PULSE and HOLDOFF.
REQ-015 In IDLE with freeze=0 and at least one press event, the FSM SHALL go to PULSE and register exactly one direction. Priority: n > s > w > e. Simultaneous lower-priority events SHALL be dropped.
REQ-016 In PULSE, exactly one of n/s/w/e SHALL be high for that one cycle. The FSM SHALL then go to HOLDOFF with the holdoff counter loaded to HOLDOFF_CYCLES-1.
REQ-017 In HOLDOFF, the counter SHALL decrement each cycle, and the FSM SHALL return to IDLE on the cycle after the counter reads 0. Press events that occur in PULSE or HOLDOFF SHALL be discarded, not queued.
REQ-018 With freeze=1, no pulse SHALL be emitted and press events SHALL be discarded in every state. If freeze rises while the FSM is in PULSE, that pulse SHALL still complete.
REQ-019 move_count SHALL increment by 1 in the cycle a pulse is output and SHALL saturate at 255.
REQ-020 Latency: for a clean press first sampled at edge 0, the pulse SHALL be high during the cycle after edge DEBOUNCE_CYCLES+2.
REQ-021 Outside PULSE, n, s, w and e SHALL be 0, so the outputs are one-hot-or-zero at all times.

Reset
REQ-022 While reset=0 at a clk edge, all of the following SHALL clear: synchronizers, deb, cnt, the edge registers, the holdoff counter, n/s/w/e, move_count and busy; the FSM SHALL enter IDLE.
REQ-023 Reset asserted during PULSE or HOLDOFF SHALL abort the operation with no further pulse. A button still held at release SHALL re-qualify through the full debounce and produce one pulse.

Structure
REQ-024 The FSM state enum and a one-hot direction typedef SHALL live in a shared package imported by this block and by the room state machine.
REQ-025 Debounce SHALL be a sub-module, button_debouncer (synchronizer + counter + deb + rise output), instantiated four times.

Verification
REQ-026 DEBOUNCE_CYCLES=4, HOLDOFF_CYCLES=2; hold btn_e high from edge 0 -> e=1 for exactly one cycle after edge 6, move_count=1, busy high for 3 cycles.
REQ-027 btn_n toggled with period 6 cycles (3 high, 3 low), DEBOUNCE_CYCLES=4 -> no pulse and move_count stays 0.
REQ-028 btn_w and btn_s rise in the same cycle -> only s pulses; a w press event arriving during HOLDOFF is dropped (move_count=1).
REQ-029 freeze=1 and btn_e pressed -> no pulse; release freeze with btn_e still held -> still no pulse (no new edge); release and re-press btn_e -> one e pulse.
REQ-030 300 qualified presses spaced 20 cycles apart -> move_count saturates at 255.
REQ-031 reset=0 for 1 cycle during PULSE -> all outputs 0 next cycle; with the button still held, one pulse DEBOUNCE_CYCLES+2 cycles after reset release.
